e2prom_arb: RTL and testbench
=============================

E2PROM_ARB -- requirements
Module: e2prom_arb

Interface
REQ-001 Parameter WR_WAIT_TIME, default 14'd12000, idle cycles after a successful write (EEPROM tWR, 12 ms at 1 MHz).
REQ-002 Parameter BUSY_TIMEOUT, default 20'd1000000, maximum cycles to wait for i2c_done before aborting.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 reqx_valid  in  1  requester x (x = 0,1) has a pending command; held until reqx_ready.
REQ-006 reqx_rh_wl  in  1  requester x direction: 1 = read, 0 = write.
REQ-007 reqx_addr  in  16  requester x EEPROM byte address.
REQ-008 reqx_wdata  in  8  requester x write data.
REQ-009 reqx_ready  out  1  one-cycle pulse: command x accepted and latched.
REQ-010 reqx_done  out  1  one-cycle pulse: command x finished.
REQ-011 reqx_rdata  out  8  read data, valid with reqx_done.
REQ-012 reqx_err  out  1  1 = NACK or timeout, valid with reqx_done.
REQ-013 i2c_exec  out  1  one-cycle start pulse to I2C master.
REQ-014 i2c_rh_wl / i2c_addr / i2c_data_w  out  1/16/8  latched command to I2C master.
REQ-015 i2c_data_r / i2c_done / i2c_ack  in  8/1/1  master read data, completion pulse, NACK flag (1 = NACK).
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, ISSUE, BUSY, WR_WAIT; one transaction outstanding on the master at any time.
REQ-018 IDLE: if any valid, grant per round-robin, latch rh_wl/addr/wdata into i2c_* registers, pulse reqx_ready same edge, go ISSUE.
REQ-019 Round-robin: both valid -> grant the requester not granted last; last_grant reset value 1 (requester 0 wins first tie).
REQ-020 ISSUE: i2c_exec = 1 for exactly one cycle, go BUSY; exec-to-ready latency is 1 cycle.
REQ-021 BUSY: on i2c_done, pulse granted reqx_done, reqx_rdata <= i2c_data_r, reqx_err <= i2c_ack.
REQ-022 BUSY exit: write with i2c_ack = 0 -> WR_WAIT; otherwise -> IDLE.
REQ-023 BUSY timeout: counter reaching BUSY_TIMEOUT-1 without i2c_done -> reqx_done with reqx_err = 1, go IDLE.
REQ-024 WR_WAIT: count WR_WAIT_TIME cycles, then IDLE; requests stay pending (no ready) during the wait.
REQ-025 i2c_done outside BUSY is ignored; valid dropping before ready is allowed, no command issued.
REQ-026 Counters clear on every state entry; no wrap beyond their terminal values.
REQ-027 Ungranted requester's done/ready remain 0; rdata/err hold last value.

Reset
REQ-028 On rst: state IDLE, all pulses 0, i2c_rh_wl 0, i2c_addr 0, i2c_data_w 0, reqx_rdata 0, reqx_err 0, counters 0, last_grant 1.
REQ-029 Reset mid-transaction abandons it with no done pulse; no i2c_exec until an IDLE grant after release.

Structure
REQ-030 Shared package e2prom_pkg holds state encoding and the default WR_WAIT_TIME / BUSY_TIMEOUT constants.
REQ-031 One sub-module natural: e2prom_rr_arb (2-way round-robin grant with last_grant register).

Verification
REQ-032 req0 write addr 0x0010 data 0xA5, ack 0 -> ready, exec 1 cycle later, done err 0, no new grant for 12000 cycles.
REQ-033 req0 and req1 valid same cycle after reset -> req0 granted first, req1 granted after req0 completes (and WR_WAIT if write).
REQ-034 req1 read addr 0x00FF, master returns 0x3C ack 0 -> req1_done, req1_rdata 0x3C, err 0, next grant immediate.
REQ-035 write with i2c_ack = 1 -> done with err 1, return to IDLE with no WR_WAIT.
REQ-036 no i2c_done for BUSY_TIMEOUT cycles -> done err 1; rst asserted in BUSY -> no done, outputs at reset values.

Source files
------------

// File: rtl/e2prom_pkg.sv
// Shared definitions for the two-requester EEPROM command arbiter:
// FSM encoding, default timing constants and the round-robin pick rule.
package e2prom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_WR_WAIT = 2'd3
  } state_t;

  localparam logic [13:0] WR_WAIT_TIME_DEF = 14'd12000;
  localparam logic [19:0] BUSY_TIMEOUT_DEF = 20'd1000000;
  localparam int          CNT_W            = 20;

  // On a tie the requester that did not win last time is chosen.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_grant);
    logic [1:0] gnt;
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/e2prom_rr_arb.sv
// Two-way round-robin grant. last_grant names the most recent winner and
// doubles as the owner index of the transaction in flight.
module e2prom_rr_arb
  import e2prom_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt,
  output logic       last_grant
);

  always_comb begin
    gnt = rr_pick(req, last_grant);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant_en && (gnt != 2'b00)) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/e2prom_arb.sv
// Arbitrates two EEPROM command requesters onto a single I2C master,
// one transaction at a time, with write-cycle hold-off and a busy timeout.
module e2prom_arb
  import e2prom_pkg::*;
#(
  parameter logic [13:0] WR_WAIT_TIME = WR_WAIT_TIME_DEF,
  parameter logic [19:0] BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  input  logic        req0_rh_wl,
  input  logic [15:0] req0_addr,
  input  logic [7:0]  req0_wdata,
  output logic        req0_ready,
  output logic        req0_done,
  output logic [7:0]  req0_rdata,
  output logic        req0_err,

  input  logic        req1_valid,
  input  logic        req1_rh_wl,
  input  logic [15:0] req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [7:0]  req1_rdata,
  output logic        req1_err,

  output logic        i2c_exec,
  output logic        i2c_rh_wl,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data_w,
  input  logic [7:0]  i2c_data_r,
  input  logic        i2c_done,
  input  logic        i2c_ack,

  output logic        busy
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         gnt;
  logic               owner;
  logic               grant_en;
  logic               exec_nxt;
  logic [1:0]         ready_nxt;
  logic               done_fire;
  logic               rdata_upd;
  logic               err_nxt;

  e2prom_rr_arb u_rr_arb (
    .clk        (clk),
    .rst        (rst),
    .req        ({req1_valid, req0_valid}),
    .grant_en   (grant_en),
    .gnt        (gnt),
    .last_grant (owner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    exec_nxt  = 1'b0;
    ready_nxt = 2'b00;
    done_fire = 1'b0;
    rdata_upd = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_en  = 1'b1;
          ready_nxt = gnt;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        exec_nxt  = 1'b1;
        state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        // A completion arriving on the last allowed cycle still wins over the timeout.
        if (i2c_done) begin
          done_fire = 1'b1;
          rdata_upd = 1'b1;
          err_nxt   = i2c_ack;
          state_nxt = (!i2c_rh_wl && !i2c_ack) ? ST_WR_WAIT : ST_IDLE;
        end else if ((cnt + 20'd1) >= BUSY_TIMEOUT) begin
          done_fire = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WR_WAIT: begin
        if ((cnt + 20'd1) >= {6'd0, WR_WAIT_TIME}) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      i2c_exec   <= 1'b0;
      i2c_rh_wl  <= 1'b0;
      i2c_addr   <= 16'd0;
      i2c_data_w <= 8'd0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_rdata <= 8'd0;
      req1_rdata <= 8'd0;
      req0_err   <= 1'b0;
      req1_err   <= 1'b0;
    end else begin
      // Counter restarts on every state change and saturates rather than wrapping.
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (((state == ST_BUSY) || (state == ST_WR_WAIT)) && (cnt != '1)) begin
        cnt <= cnt + 20'd1;
      end

      i2c_exec   <= exec_nxt;
      req0_ready <= ready_nxt[0];
      req1_ready <= ready_nxt[1];
      req0_done  <= done_fire && !owner;
      req1_done  <= done_fire && owner;

      if (grant_en) begin
        i2c_rh_wl  <= gnt[1] ? req1_rh_wl : req0_rh_wl;
        i2c_addr   <= gnt[1] ? req1_addr  : req0_addr;
        i2c_data_w <= gnt[1] ? req1_wdata : req0_wdata;
      end

      if (done_fire) begin
        if (owner) begin
          req1_err <= err_nxt;
          if (rdata_upd) req1_rdata <= i2c_data_r;
        end else begin
          req0_err <= err_nxt;
          if (rdata_upd) req0_rdata <= i2c_data_r;
        end
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_e2prom_arb.sv
// Self-checking bench for e2prom_arb: directed scenarios then randomized traffic,
// checked against an event-level reference model of arbitration and timing.
`timescale 1ns/1ps
module tb_e2prom_arb;

  localparam logic [13:0] WW  = 14'd50;
  localparam logic [19:0] TO  = 20'd100;
  localparam int          WWI = 50;
  localparam int          TOI = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_rh_wl, req0_ready, req0_done, req0_err;
  logic [15:0] req0_addr;
  logic [7:0]  req0_wdata, req0_rdata;
  logic        req1_valid, req1_rh_wl, req1_ready, req1_done, req1_err;
  logic [15:0] req1_addr;
  logic [7:0]  req1_wdata, req1_rdata;
  logic        i2c_exec, i2c_rh_wl, i2c_done, i2c_ack, busy;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w, i2c_data_r;

  int          n_cmp  = 0;
  int          n_fail = 0;

  // Reference model state
  int          m_last;
  int          m_lat;
  logic [7:0]  m_rdata [2];
  logic        m_err   [2];

  always #5 clk = ~clk;

  e2prom_arb #(.WR_WAIT_TIME(WW), .BUSY_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_rh_wl (req0_rh_wl),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .req0_done  (req0_done),
    .req0_rdata (req0_rdata),
    .req0_err   (req0_err),
    .req1_valid (req1_valid),
    .req1_rh_wl (req1_rh_wl),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .req1_done  (req1_done),
    .req1_rdata (req1_rdata),
    .req1_err   (req1_err),
    .i2c_exec   (i2c_exec),
    .i2c_rh_wl  (i2c_rh_wl),
    .i2c_addr   (i2c_addr),
    .i2c_data_w (i2c_data_w),
    .i2c_data_r (i2c_data_r),
    .i2c_done   (i2c_done),
    .i2c_ack    (i2c_ack),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic rw, input logic [15:0] a, input logic [7:0] wd);
    if (r == 0) begin
      req0_valid = 1'b1; req0_rh_wl = rw; req0_addr = a; req0_wdata = wd;
    end else begin
      req1_valid = 1'b1; req1_rh_wl = rw; req1_addr = a; req1_wdata = wd;
    end
  endtask

  // One complete transaction: wait for the grant, act as the I2C master
  // (mode 0 = ack, 1 = nack, 2 = never answer), then check completion.
  task automatic serve(input int mode, input logic [7:0] rd, input int d, input string tag);
    int          who;
    int          lat;
    logic        rw;
    logic [15:0] a;
    logic [7:0]  wd;
    logic        wr_wait;
    who = (req0_valid && req1_valid) ? (1 - m_last) : (req1_valid ? 1 : 0);
    rw  = (who == 1) ? req1_rh_wl : req0_rh_wl;
    a   = (who == 1) ? req1_addr  : req0_addr;
    wd  = (who == 1) ? req1_wdata : req0_wdata;

    lat = 0;
    for (int k = 1; k <= WWI + 20; k++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        lat = k;
        break;
      end
    end
    chk({tag, " ready latency"}, lat, m_lat);
    if (lat == 0) return;
    m_last = who;
    chk({tag, " ready0"}, req0_ready, (who == 0));
    chk({tag, " ready1"}, req1_ready, (who == 1));
    chk({tag, " exec early"}, i2c_exec, 1'b0);
    chk({tag, " i2c_rh_wl"}, i2c_rh_wl, rw);
    chk({tag, " i2c_addr"}, i2c_addr, a);
    chk({tag, " i2c_data_w"}, i2c_data_w, wd);
    chk({tag, " busy at grant"}, busy, 1'b1);
    if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;

    @(negedge clk);
    chk({tag, " exec"}, i2c_exec, 1'b1);
    chk({tag, " ready pulse width"}, req0_ready | req1_ready, 1'b0);

    lat = 0;
    for (int j = 1; j <= TOI + 5; j++) begin
      @(negedge clk);
      if (req0_done || req1_done) begin
        lat = j;
        break;
      end
      if (j == 1) chk({tag, " exec pulse width"}, i2c_exec, 1'b0);
      i2c_done   = (mode != 2) && (j == d);
      i2c_data_r = rd;
      i2c_ack    = (mode == 1);
    end
    i2c_done = 1'b0;
    i2c_ack  = 1'b0;
    chk({tag, " done latency"}, lat, (mode == 2) ? TOI : d + 1);
    if (lat == 0) return;

    if (mode != 2) m_rdata[who] = rd;
    m_err[who] = (mode != 0);
    wr_wait    = (rw == 1'b0) && (mode == 0);
    chk({tag, " done0"}, req0_done, (who == 0));
    chk({tag, " done1"}, req1_done, (who == 1));
    chk({tag, " rdata0"}, req0_rdata, m_rdata[0]);
    chk({tag, " rdata1"}, req1_rdata, m_rdata[1]);
    chk({tag, " err0"}, req0_err, m_err[0]);
    chk({tag, " err1"}, req1_err, m_err[1]);
    chk({tag, " busy after done"}, busy, wr_wait);
    m_lat = wr_wait ? WWI + 1 : 1;
  endtask

  initial begin
    logic seen;
    int   x;
    int   mode;
    rst = 1'b1;
    req0_valid = 1'b0; req0_rh_wl = 1'b0; req0_addr = 16'd0; req0_wdata = 8'd0;
    req1_valid = 1'b0; req1_rh_wl = 1'b0; req1_addr = 16'd0; req1_wdata = 8'd0;
    i2c_data_r = 8'd0; i2c_done = 1'b0; i2c_ack = 1'b0;
    m_last = 1; m_lat = 1;
    m_rdata[0] = 8'd0; m_rdata[1] = 8'd0; m_err[0] = 1'b0; m_err[1] = 1'b0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst exec", i2c_exec, 1'b0);
    chk("rst i2c_addr", i2c_addr, 16'd0);
    chk("rst i2c_data_w", i2c_data_w, 8'd0);
    chk("rst i2c_rh_wl", i2c_rh_wl, 1'b0);
    chk("rst pulses", {req0_ready, req1_ready, req0_done, req1_done}, 4'b0000);
    chk("rst rdata", {req0_rdata, req1_rdata}, 16'd0);
    chk("rst err", {req0_err, req1_err}, 2'b00);
    rst = 1'b0;

    // Simultaneous requests: req0 write wins, then req1 read after the write wait
    set_req(0, 1'b0, 16'h0010, 8'hA5);
    set_req(1, 1'b1, 16'h00FF, 8'h00);
    serve(0, 8'h11, 3, "wr0");
    serve(0, 8'h3C, 5, "rd1");

    // Read completion lets the next grant through immediately
    set_req(0, 1'b1, 16'h0200, 8'h00);
    serve(0, 8'hC3, 1, "rd0");

    // Write NACK: error and no write wait
    set_req(1, 1'b0, 16'h0300, 8'h5A);
    serve(1, 8'h77, 4, "wrnack1");

    // Master never answers: timeout with error
    set_req(0, 1'b1, 16'h0400, 8'h00);
    serve(2, 8'hEE, 0, "timeout0");

    // Stray i2c_done while idle must be ignored
    i2c_done = 1'b1; i2c_ack = 1'b1; i2c_data_r = 8'h99;
    @(negedge clk);
    i2c_done = 1'b0; i2c_ack = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen = seen | req0_done | req1_done | busy;
    end
    chk("stray done ignored", seen, 1'b0);
    chk("stray rdata0", req0_rdata, m_rdata[0]);
    m_lat = 1;

    // Request withdrawn during the write wait is never granted
    set_req(1, 1'b0, 16'h0500, 8'h42);
    serve(0, 8'h00, 2, "wr1");
    seen = 1'b0;
    for (int k = 1; k <= WWI + 5; k++) begin
      @(negedge clk);
      seen = seen | req0_ready | req1_ready | i2c_exec;
      if (k == 5)  set_req(0, 1'b1, 16'h0600, 8'h00);
      if (k == 15) req0_valid = 1'b0;
    end
    chk("withdrawn request", seen, 1'b0);
    chk("idle after wait", busy, 1'b0);
    m_lat = 1;

    // Reset while BUSY abandons the transaction
    set_req(0, 1'b1, 16'h1234, 8'h5A);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (req0_ready) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst-test grant", seen, 1'b1);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid rst busy", busy, 1'b0);
    chk("mid rst i2c_addr", i2c_addr, 16'd0);
    chk("mid rst i2c_rh_wl", i2c_rh_wl, 1'b0);
    chk("mid rst rdata1", req1_rdata, 8'd0);
    chk("mid rst err", {req0_err, req1_err}, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen = seen | i2c_exec | req0_done | req1_done | busy;
    end
    chk("quiet after rst", seen, 1'b0);
    m_last = 1; m_lat = 1;
    m_rdata[0] = 8'd0; m_rdata[1] = 8'd0; m_err[0] = 1'b0; m_err[1] = 1'b0;

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      if (!req0_valid && ($urandom_range(0, 99) < 60))
        set_req(0, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
      if (!req1_valid && ($urandom_range(0, 99) < 60))
        set_req(1, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
      if (!req0_valid && !req1_valid)
        set_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
      x    = int'($urandom_range(0, 19));
      mode = (x < 14) ? 0 : ((x < 19) ? 1 : 2);
      serve(mode, 8'($urandom), int'($urandom_range(1, 20)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
